// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-pattern detector.
// A pattern of 1..MAX_LEN bits, its length and the overlap mode are loaded
// through the cfg_* port. Valid-qualified serial bits are shifted into a
// history register. The incoming bit is compared combinationally against the
// programmed pattern, and a registered match pulse follows one clock later.
// A saturating counter tallies matches since reset or the last legal config.
//
// Handshake: din is consumed on every rising edge where din_valid=1; there is
// no back-pressure. cfg_load is a single-cycle strobe; a legal config takes
// priority over din in the same cycle.
module seq_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               cfg_err,
  output logic               armed,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat,
  output logic [1:0]         state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t             state;
  logic [MAX_LEN-1:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic               ovl_r;

  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W:0]     fill_inc;
  logic [LEN_W-1:0]   fill_next;
  logic               fill_ok;
  logic               hit;
  logic               legal_cfg;
  logic [CNT_W-1:0]   cnt_inc;

  assign state_dbg = state;

  // Candidate window, length mask and the combinational hit decision.
  always_comb begin
    cand     = {hist[MAX_LEN-2:0], din};
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_r));
    end
    fill_inc  = {1'b0, fill} + {{LEN_W{1'b0}}, 1'b1};
    fill_next = (fill_inc > {1'b0, MAX_LEN_L}) ? MAX_LEN_L : fill_inc[LEN_W-1:0];
    fill_ok   = (fill_inc >= {1'b0, len_r});
    hit       = din_valid && (state != IDLE) && fill_ok &&
                (((cand ^ pat_r) & len_mask) == '0);
    legal_cfg = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
    cnt_inc   = match_count + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  // Detector FSM, history/fill tracking, counter and registered pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      hist        <= '0;
      fill        <= '0;
      pat_r       <= '0;
      len_r       <= '0;
      ovl_r       <= 1'b0;
      cfg_err     <= 1'b0;
      armed       <= 1'b0;
      match       <= 1'b0;
      match_count <= '0;
      count_sat   <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      match   <= 1'b0;
      if (cfg_load && legal_cfg) begin
        // A legal config wins over any din in the same cycle.
        pat_r       <= cfg_pattern;
        len_r       <= cfg_len;
        ovl_r       <= cfg_overlap;
        hist        <= '0;
        fill        <= '0;
        match_count <= '0;
        count_sat   <= 1'b0;
        state       <= FILL;
        armed       <= 1'b1;
      end else begin
        // An illegal length is flagged but the current bit is still processed.
        if (cfg_load) begin
          cfg_err <= 1'b1;
        end
        if ((state != IDLE) && din_valid) begin
          match <= hit;
          if (hit && (match_count != CNT_MAX)) begin
            match_count <= cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              count_sat <= 1'b1;
            end
          end
          if (hit && !ovl_r) begin
            // Non-overlapping mode: the next match must be built from fresh bits.
            hist  <= '0;
            fill  <= '0;
            state <= FILL;
          end else begin
            hist  <= cand;
            fill  <= fill_next;
            state <= (fill_next >= len_r) ? RUN : FILL;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog (MAX_LEN=8, CNT_W=4).
module tb_seq_detect_prog;

  logic       clk;
  logic       reset;
  logic       din;
  logic       din_valid;
  logic       cfg_load;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       cfg_overlap;
  logic       cfg_err;
  logic       armed;
  logic       match;
  logic [3:0] match_count;
  logic       count_sat;
  logic [1:0] state_dbg;

  int checks;
  int failures;

  typedef struct {
    logic       rst;
    logic       dv;
    logic       d;
    logic       ld;
    logic [7:0] pat;
    logic [3:0] len;
    logic       ovl;
    logic       e_match;
    logic [3:0] e_cnt;
    logic       e_armed;
    logic       e_err;
    logic       e_sat;
  } vec_t;

  vec_t vecs[$];

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .din_valid   (din_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cfg_err     (cfg_err),
    .armed       (armed),
    .match       (match),
    .match_count (match_count),
    .count_sat   (count_sat),
    .state_dbg   (state_dbg)
  );

  // Clock and idle inputs
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(logic rst, logic dv, logic d, logic ld, logic [7:0] pat,
                              logic [3:0] len, logic ovl, logic em, logic [3:0] ec,
                              logic ea, logic ee, logic es);
    vec_t v;
    v.rst = rst; v.dv = dv; v.d = d; v.ld = ld; v.pat = pat; v.len = len; v.ovl = ovl;
    v.e_match = em; v.e_cnt = ec; v.e_armed = ea; v.e_err = ee; v.e_sat = es;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  // Drive one vector on the falling edge, check outputs just after the rising edge.
  task automatic apply(vec_t v, int idx);
    @(negedge clk);
    reset       = v.rst;
    din_valid   = v.dv;
    din         = v.d;
    cfg_load    = v.ld;
    cfg_pattern = v.pat;
    cfg_len     = v.len;
    cfg_overlap = v.ovl;
    @(posedge clk);
    #1;
    check("match",       idx, {7'd0, match},       {7'd0, v.e_match});
    check("match_count", idx, {4'd0, match_count}, {4'd0, v.e_cnt});
    check("armed",       idx, {7'd0, armed},       {7'd0, v.e_armed});
    check("cfg_err",     idx, {7'd0, cfg_err},     {7'd0, v.e_err});
    check("count_sat",   idx, {7'd0, count_sat},   {7'd0, v.e_sat});
  endtask

  initial begin
    int step;
    checks = 0;
    failures = 0;
    reset = 1'b1; din = 1'b0; din_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    step = 0;

    // Reset, then unconfigured stream is ignored
    vecs.push_back(mk(1,0,0,0,8'h00,0,0, 0,0,0,0,0));
    vecs.push_back(mk(1,1,1,0,8'h00,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,8'h00,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,1,0,8'h00,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0, 0,0,0,0,0));
    // len=3 pat=101 overlap=1, din in the cfg cycle is dropped
    vecs.push_back(mk(0,1,1,1,8'h05,3,1, 0,0,1,0,0));
    vecs.push_back(mk(0,1,1,0,8'h00,0,0, 0,0,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0, 0,0,1,0,0));
    vecs.push_back(mk(0,1,1,0,8'h00,0,0, 1,1,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0, 0,1,1,0,0));
    vecs.push_back(mk(0,1,1,0,8'h00,0,0, 1,2,1,0,0));
    // Same pattern overlap=0: only one match in 10101, then fresh 101 matches
    vecs.push_back(mk(0,0,0,1,8'h05,3,0, 0,0,1,0,0));
    vecs.push_back(mk(0,1,1,0,8'h00,0,0, 0,0,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0, 0,0,1,0,0));
    vecs.push_back(mk(0,1,1,0,8'h00,0,0, 1,1,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0, 0,1,1,0,0));
    vecs.push_back(mk(0,1,1,0,8'h00,0,0, 0,1,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0, 0,1,1,0,0));
    vecs.push_back(mk(0,1,1,0,8'h00,0,0, 1,2,1,0,0));
    // len=5 pat=10100 with valid gaps in the middle
    vecs.push_back(mk(0,0,0,1,8'h14,5,1, 0,0,1,0,0));
    vecs.push_back(mk(0,1,1,0,8'h00,0,0, 0,0,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0, 0,0,1,0,0));
    vecs.push_back(mk(0,0,1,0,8'h00,0,0, 0,0,1,0,0));
    vecs.push_back(mk(0,0,1,0,8'h00,0,0, 0,0,1,0,0));
    vecs.push_back(mk(0,0,1,0,8'h00,0,0, 0,0,1,0,0));
    vecs.push_back(mk(0,1,1,0,8'h00,0,0, 0,0,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0, 0,0,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0, 1,1,1,0,0));
    // Illegal cfg_len=0 while running: err pulse, din still shifted in
    vecs.push_back(mk(0,1,1,1,8'hFF,0,0, 0,1,1,1,0));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0, 0,1,1,0,0));
    vecs.push_back(mk(0,1,1,0,8'h00,0,0, 0,1,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0, 0,1,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0, 1,2,1,0,0));
    // Illegal cfg_len=9 (> MAX_LEN): config kept
    vecs.push_back(mk(0,0,0,1,8'h00,9,0, 0,2,1,1,0));
    vecs.push_back(mk(0,1,1,0,8'h00,0,0, 0,2,1,0,0));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0, 0,2,1,0,0));
    // Reset mid-pattern: config lost, din ignored afterwards
    vecs.push_back(mk(1,1,1,0,8'h00,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,8'h00,0,0, 0,0,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], step);
      step++;
    end

    // Counter saturation with len=1 pat=1: 20 ones, count stops at 15
    apply(mk(0,0,0,1,8'h01,1,0, 0,0,1,0,0), step); step++;
    for (int k = 1; k <= 20; k++) begin
      apply(mk(0,1,1,0,8'h00,0,0, 1,(k >= 15) ? 4'd15 : 4'(k),1,0,(k >= 15)), step);
      step++;
    end
    apply(mk(0,1,0,0,8'h00,0,0, 0,15,1,0,1), step); step++;
    // count_sat holds across an illegal load, clears on a legal one
    apply(mk(0,0,0,1,8'h00,0,0, 0,15,1,1,1), step); step++;
    apply(mk(0,0,0,1,8'h00,1,1, 0,0,1,0,0), step); step++;
    // len=1 pat=0 overlap=1: every valid 0 matches
    apply(mk(0,1,0,0,8'h00,0,0, 1,1,1,0,0), step); step++;
    apply(mk(0,1,0,0,8'h00,0,0, 1,2,1,0,0), step); step++;
    apply(mk(0,1,1,0,8'h00,0,0, 0,2,1,0,0), step); step++;
    apply(mk(0,0,0,0,8'h00,0,0, 0,2,1,0,0), step); step++;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
